// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver with frame snapshot, LZ blanking and blink.
// Outputs are registered one cycle behind the scan index.
module seg7_scan_mux #(
    parameter int N_DIGITS       = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter int HEX_EN         = 0,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic                    blank_lz,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     ds,
    output logic                    frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [7:0] UNLIT = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] sh_dig_q, sh_dig_d;
    logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [N_DIGITS-1:0]   sh_bm_q, sh_bm_d;
    logic [FW-1:0]         fc_q, fc_d;
    logic                  ph_q, ph_d;
    logic                  lp_q, lp_d;
    logic                  fs_q, fs_d;
    logic [N_DIGITS-1:0]   ds_q, ds_d;
    logic [7:0]            seg_q, seg_d;

    logic                  tick, snap;
    logic [4*N_DIGITS-1:0] cur_dig;
    logic [N_DIGITS-1:0]   cur_dp, cur_bm;
    logic                  cur_ph;
    logic [3:0]            nib;
    logic                  lead_zero, lz_dark, blink_dark;
    logic [7:0]            seg_raw;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = (HEX_EN != 0) ? 7'h77 : 7'h00;
            4'hB: g = (HEX_EN != 0) ? 7'h7C : 7'h00;
            4'hC: g = (HEX_EN != 0) ? 7'h39 : 7'h00;
            4'hD: g = (HEX_EN != 0) ? 7'h5E : 7'h00;
            4'hE: g = (HEX_EN != 0) ? 7'h79 : 7'h00;
            default: g = (HEX_EN != 0) ? 7'h71 : 7'h00;
        endcase
        return g;
    endfunction

    always_comb begin
        tick  = en && (cnt_q == CW'(SCAN_DIV - 1));
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == '0) ? IW'(N_DIGITS - 1) : idx_q - 1'b1;
        end

        snap     = en && ((tick && (idx_q == '0)) || lp_q);
        sh_dig_d = snap ? digits : sh_dig_q;
        sh_dp_d  = snap ? dp : sh_dp_q;
        sh_bm_d  = snap ? blink_mask : sh_bm_q;
        lp_d     = lp_q && !snap;
        fs_d     = snap;

        fc_d = fc_q;
        ph_d = ph_q;
        if (snap) begin
            if (fc_q == FW'(BLINK_FRAMES - 1)) begin
                fc_d = '0;
                ph_d = !ph_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end

        // The very first slot after reset shows the data being captured now.
        cur_dig = lp_q ? sh_dig_d : sh_dig_q;
        cur_dp  = lp_q ? sh_dp_d : sh_dp_q;
        cur_bm  = lp_q ? sh_bm_d : sh_bm_q;
        cur_ph  = lp_q ? ph_d : ph_q;

        nib       = cur_dig[4*idx_q +: 4];
        lead_zero = 1'b1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(idx_q) && cur_dig[4*j +: 4] != 4'h0) begin
                lead_zero = 1'b0;
            end
        end
        lz_dark    = blank_lz && (idx_q != '0) && lead_zero;
        blink_dark = cur_ph && cur_bm[idx_q];

        seg_raw = 8'h00;
        if (!blink_dark) begin
            seg_raw = {cur_dp[idx_q], lz_dark ? 7'h00 : glyph(nib)};
        end

        ds_d  = '1;
        seg_d = UNLIT;
        if (en) begin
            ds_d[idx_q] = 1'b0;
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= IW'(N_DIGITS - 1);
            sh_dig_q <= '0;
            sh_dp_q  <= '0;
            sh_bm_q  <= '0;
            fc_q     <= '0;
            ph_q     <= 1'b0;
            lp_q     <= 1'b1;
            fs_q     <= 1'b0;
            ds_q     <= '1;
            seg_q    <= UNLIT;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_dig_q <= sh_dig_d;
            sh_dp_q  <= sh_dp_d;
            sh_bm_q  <= sh_bm_d;
            fc_q     <= fc_d;
            ph_q     <= ph_d;
            lp_q     <= lp_d;
            fs_q     <= fs_d;
            ds_q     <= ds_d;
            seg_q    <= seg_d;
        end
    end

    assign seg         = seg_q;
    assign ds          = ds_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: two configurations checked cycle by cycle
// against a schedule-based reference model.
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [31:0] dig_a;
    logic [15:0] dig_b;
    logic [7:0]  dp_a, bm_a;
    logic [3:0]  dp_b, bm_b;
    logic        lz_a, lz_b;
    logic [7:0]  seg_a, seg_b;
    logic [7:0]  ds_a;
    logic [3:0]  ds_b;
    logic        fs_a, fs_b;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .N_DIGITS(8), .SCAN_DIV(4), .BLINK_FRAMES(2),
        .HEX_EN(1), .SEG_ACTIVE_LOW(0)
    ) u_a (
        .clk(clk), .rst(rst), .en(en_a), .digits(dig_a),
        .dp(dp_a), .blink_mask(bm_a), .blank_lz(lz_a),
        .seg(seg_a), .ds(ds_a), .frame_start(fs_a)
    );

    seg7_scan_mux #(
        .N_DIGITS(4), .SCAN_DIV(3), .BLINK_FRAMES(1),
        .HEX_EN(0), .SEG_ACTIVE_LOW(1)
    ) u_b (
        .clk(clk), .rst(rst), .en(en_b), .digits(dig_b),
        .dp(dp_b), .blink_mask(bm_b), .blank_lz(lz_b),
        .seg(seg_b), .ds(ds_b), .frame_start(fs_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int pn[2], psd[2], pbf[2], phex[2], pal[2];
    logic [6:0] glyph_tbl [0:15];

    // Model: active-cycle count since reset, snapshot count, captured frame.
    int          mk[2], mns[2];
    logic [63:0] mdig[2];
    logic [15:0] mdp[2], mbm[2];
    logic [15:0] eds[2];
    logic [7:0]  eseg[2];
    logic        efs[2];

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input int i, input logic r, input logic e,
                         input logic [63:0] dg, input logic [15:0] dpv,
                         input logic [15:0] bmv, input logic lz);
        int n, d, code, ph;
        logic snap, dark, lzd;
        logic [7:0] s;
        logic [15:0] all1;
        n = pn[i];
        all1 = 16'((32'd1 << n) - 1);
        if (r) begin
            mk[i] = 0; mns[i] = 0;
            mdig[i] = '0; mdp[i] = '0; mbm[i] = '0;
            eds[i] = all1;
            eseg[i] = (pal[i] != 0) ? 8'hFF : 8'h00;
            efs[i] = 1'b0;
        end else if (!e) begin
            eds[i] = all1;
            eseg[i] = (pal[i] != 0) ? 8'hFF : 8'h00;
            efs[i] = 1'b0;
        end else begin
            snap = (mk[i] == 0) || ((mk[i] + 1) % (n * psd[i]) == 0);
            if (mk[i] == 0) begin
                mdig[i] = dg; mdp[i] = dpv; mbm[i] = bmv;
                mns[i]++;
            end
            d = n - 1 - (mk[i] / psd[i]) % n;
            ph = (mns[i] / pbf[i]) % 2;
            code = int'((mdig[i] >> (4 * d)) & 64'hF);
            lzd = lz && (d > 0) && ((mdig[i] >> (4 * d)) == 64'd0);
            dark = (ph == 1) && mbm[i][d];
            s = 8'h00;
            if (!dark) begin
                s[7] = mdp[i][d];
                if (lzd || (code > 9 && phex[i] == 0)) s[6:0] = 7'h00;
                else s[6:0] = glyph_tbl[code];
            end
            eseg[i] = (pal[i] != 0) ? ~s : s;
            eds[i] = all1 & ~(16'd1 << d);
            efs[i] = snap;
            if (mk[i] != 0 && snap) begin
                mdig[i] = dg; mdp[i] = dpv; mbm[i] = bmv;
                mns[i]++;
            end
            mk[i]++;
        end
    endtask

    task automatic cyc();
        model(0, rst, en_a, 64'(dig_a), 16'(dp_a), 16'(bm_a), lz_a);
        model(1, rst, en_b, 64'(dig_b), 16'(dp_b), 16'(bm_b), lz_b);
        @(posedge clk);
        #1;
        chk("ds_a", 16'(ds_a), eds[0]);
        chk("seg_a", 16'(seg_a), 16'(eseg[0]));
        chk("fs_a", 16'(fs_a), 16'(efs[0]));
        chk("ds_b", 16'(ds_b), eds[1]);
        chk("seg_b", 16'(seg_b), 16'(eseg[1]));
        chk("fs_b", 16'(fs_b), 16'(efs[1]));
    endtask

    logic [7:0] seq1 [0:7];
    logic [7:0] ds_exp;

    initial begin
        pn   = '{8, 4};
        psd  = '{4, 3};
        pbf  = '{2, 1};
        phex = '{1, 0};
        pal  = '{0, 1};
        glyph_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        seq1 = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};

        rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
        dig_a = '0; dig_b = '0; dp_a = '0; dp_b = '0;
        bm_a = '0; bm_b = '0; lz_a = 1'b0; lz_b = 1'b0;
        cyc();
        cyc();
        chk("rst_ds_a", 16'(ds_a), 16'h00FF);
        chk("rst_seg_a", 16'(seg_a), 16'h0000);
        chk("rst_seg_b", 16'(seg_b), 16'h00FF);
        chk("rst_fs_a", 16'(fs_a), 16'h0000);

        // Basic scan of 0x12345678, MSB digit first, four clocks per slot.
        rst = 1'b0; en_a = 1'b1; en_b = 1'b1;
        dig_a = 32'h12345678; dig_b = 16'hBBBB;
        for (int j = 0; j < 64; j++) begin
            cyc();
            if (j < 32) begin
                ds_exp = ~(8'h80 >> (j / 4));
                chk("t1_ds", 16'(ds_a), 16'(ds_exp));
                chk("t1_seg", 16'(seg_a), 16'(seq1[j / 4]));
            end
            if (j == 0) begin
                chk("t1_fs", 16'(fs_a), 16'h0001);
                chk("t5_seg_b", 16'(seg_b), 16'h00FF);
            end
        end

        // Mid-frame data change stays hidden until the next snapshot.
        for (int j = 0; j < 9; j++) cyc();
        dig_a = 32'h99999999;
        for (int j = 0; j < 40; j++) cyc();

        // Leading-zero blanking with a decimal point on a blanked digit.
        lz_a = 1'b1; dig_a = 32'h00000050; dp_a = 8'h04;
        for (int j = 0; j < 80; j++) cyc();

        // Blink on digit 0.
        lz_a = 1'b0; dp_a = 8'h00; dig_a = 32'h00000000; bm_a = 8'h01;
        for (int j = 0; j < 200; j++) cyc();

        // Hex glyph vs blanked hex with inverted outputs.
        bm_a = 8'h00; dig_a = 32'hBBBBBBBB;
        for (int j = 0; j < 40; j++) cyc();
        chk("t5_seg_a", 16'(seg_a), 16'h007C);
        chk("t5_seg_b2", 16'(seg_b), 16'h00FF);

        // Enable pause and mid-frame reset.
        dig_a = 32'h12345678;
        for (int j = 0; j < 13; j++) cyc();
        en_a = 1'b0;
        cyc();
        chk("t6_ds_off", 16'(ds_a), 16'h00FF);
        chk("t6_seg_off", 16'(seg_a), 16'h0000);
        for (int j = 0; j < 3; j++) cyc();
        en_a = 1'b1;
        for (int j = 0; j < 10; j++) cyc();
        rst = 1'b1;
        cyc();
        chk("t6_ds_rst", 16'(ds_a), 16'h00FF);
        rst = 1'b0;
        cyc();
        chk("t6_ds_restart", 16'(ds_a), 16'h007F);
        for (int j = 0; j < 20; j++) cyc();

        // Randomized traffic against the model.
        for (int j = 0; j < 1500; j++) begin
            rst = ($urandom_range(0, 499) == 0);
            if (en_a) en_a = ($urandom_range(0, 39) != 0);
            else en_a = ($urandom_range(0, 3) == 0);
            if (en_b) en_b = ($urandom_range(0, 39) != 0);
            else en_b = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                dig_a = $urandom >> (4 * $urandom_range(0, 8));
                dig_b = 16'($urandom >> (4 * $urandom_range(4, 8)));
                dp_a = 8'($urandom);
                dp_b = 4'($urandom);
            end
            if ($urandom_range(0, 19) == 0) begin
                bm_a = 8'($urandom);
                bm_b = 4'($urandom);
                lz_a = 1'($urandom);
                lz_b = 1'($urandom);
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
